// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-request load/store unit with lane alignment and load extension
module mem_access_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [2:0]          req_size,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_misalign,
  output logic                bus_valid,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [2:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_strobe,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam logic [1:0] SZ_MAX = 2'(OW);
  localparam logic [6:0] DW7 = 7'(DATA_W);
  localparam logic [DATA_W-1:0] ONE_W = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic              usign_q, usign_d;
  logic [OW-1:0]     off_q, off_d;
  logic              bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [2:0]        bus_size_q, bus_size_d;
  logic [NB-1:0]     bus_strobe_q, bus_strobe_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_misalign_q, resp_misalign_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              accept;
  logic [1:0]        acc_sz;
  logic [OW-1:0]     acc_off;
  logic [3:0]        acc_bytes;
  logic [15:0]       acc_bmask;
  logic [NB-1:0]     acc_strobe;
  logic [2:0]        acc_amask;
  logic              acc_misalign;
  logic              acc_illegal;
  logic              acc_fault;
  logic [DATA_W-1:0] acc_wdata;

  logic [DATA_W-1:0] ld_field;
  logic [6:0]        ld_nbits;
  logic [DATA_W-1:0] ld_mask;
  logic [DATA_W-1:0] ld_top;
  logic              ld_sign;
  logic [DATA_W-1:0] ld_data;

  // address-accepted handshake carries no state change; kept only for visibility
  logic unused_addr_ok;
  assign unused_addr_ok = bus_addr_ok;

  assign req_ready     = (state_q == S_IDLE) && !reset;
  assign accept        = req_valid && req_ready;

  assign bus_valid     = bus_valid_q;
  assign bus_addr      = bus_addr_q;
  assign bus_size      = bus_size_q;
  assign bus_strobe    = bus_strobe_q;
  assign bus_wdata     = bus_wdata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_misalign = resp_misalign_q;
  assign resp_rdata    = resp_rdata_q;

  // lane placement and fault detection for the request being offered
  always_comb begin
    acc_sz     = req_size[1:0];
    acc_off    = req_addr[OW-1:0];
    acc_bytes  = 4'd1 << acc_sz;
    acc_bmask  = (16'd1 << acc_bytes) - 16'd1;
    acc_strobe = NB'(acc_bmask << acc_off);
    acc_wdata  = req_wdata << {acc_off, 3'b000};
    case (acc_sz)
      2'd0:    acc_amask = 3'b000;
      2'd1:    acc_amask = 3'b001;
      2'd2:    acc_amask = 3'b011;
      default: acc_amask = 3'b111;
    endcase
    acc_misalign = |(req_addr[2:0] & acc_amask);
    acc_illegal  = acc_sz > SZ_MAX;
    acc_fault    = acc_misalign || acc_illegal;
  end

  // shift the addressed field down and sign- or zero-extend it; the sign bit is
  // found as the top set bit of the width mask so no variable bit index is needed
  always_comb begin
    ld_field = bus_rdata >> {off_q, 3'b000};
    ld_nbits = 7'd8 << bus_size_q[1:0];
    ld_mask  = (ld_nbits >= DW7) ? {DATA_W{1'b1}} : ((ONE_W << ld_nbits) - ONE_W);
    ld_top   = ld_mask & ~(ld_mask >> 1);
    ld_sign  = (|(ld_field & ld_top)) && !usign_q;
    ld_data  = ld_sign ? (ld_field | ~ld_mask) : (ld_field & ld_mask);
  end

  // next-state and registered-output computation for IDLE/BUS/RESP
  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    usign_d         = usign_q;
    off_d           = off_q;
    bus_valid_d     = bus_valid_q;
    bus_addr_d      = bus_addr_q;
    bus_size_d      = bus_size_q;
    bus_strobe_d    = bus_strobe_q;
    bus_wdata_d     = bus_wdata_q;
    resp_valid_d    = 1'b0;
    resp_misalign_d = 1'b0;
    resp_rdata_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = req_write;
          usign_d = req_size[2];
          off_d   = acc_off;
          if (acc_fault) begin
            state_d         = S_RESP;
            resp_valid_d    = 1'b1;
            resp_misalign_d = 1'b1;
          end else begin
            state_d      = S_BUS;
            bus_valid_d  = 1'b1;
            bus_addr_d   = req_addr;
            bus_size_d   = {1'b0, acc_sz};
            bus_strobe_d = req_write ? acc_strobe : '0;
            bus_wdata_d  = acc_wdata;
          end
        end
      end
      S_BUS: begin
        if (bus_data_ok) begin
          state_d      = S_RESP;
          bus_valid_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? '0 : ld_data;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers; reset abandons any in-flight transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      write_q         <= 1'b0;
      usign_q         <= 1'b0;
      off_q           <= '0;
      bus_valid_q     <= 1'b0;
      bus_addr_q      <= '0;
      bus_size_q      <= '0;
      bus_strobe_q    <= '0;
      bus_wdata_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_misalign_q <= 1'b0;
      resp_rdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      usign_q         <= usign_d;
      off_q           <= off_d;
      bus_valid_q     <= bus_valid_d;
      bus_addr_q      <= bus_addr_d;
      bus_size_q      <= bus_size_d;
      bus_strobe_q    <= bus_strobe_d;
      bus_wdata_q     <= bus_wdata_d;
      resp_valid_q    <= resp_valid_d;
      resp_misalign_q <= resp_misalign_d;
      resp_rdata_q    <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit at 64- and 32-bit widths
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid64, req_valid32;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_size;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [63:0] bus_rdata;

  logic        rdy64, rv64, mis64, bv64;
  logic [63:0] rd64, ba64, bw64;
  logic [2:0]  bs64;
  logic [7:0]  bst64;

  logic        rdy32, rv32, mis32, bv32;
  logic [31:0] rd32, ba32, bw32;
  logic [2:0]  bs32;
  logic [3:0]  bst32;

  mem_access_unit #(.DATA_W(64), .ADDR_W(64)) u64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid64), .req_ready(rdy64), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(rv64), .resp_rdata(rd64), .resp_misalign(mis64),
    .bus_valid(bv64), .bus_addr(ba64), .bus_size(bs64), .bus_strobe(bst64),
    .bus_wdata(bw64), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid32), .req_ready(rdy32), .req_write(req_write),
    .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]), .req_size(req_size),
    .resp_valid(rv32), .resp_rdata(rd32), .resp_misalign(mis32),
    .bus_valid(bv32), .bus_addr(ba32), .bus_size(bs32), .bus_strobe(bst32),
    .bus_wdata(bw32), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata[31:0])
  );

  typedef struct {
    bit          sel;
    logic [63:0] rdata;
    bit          fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cur_sel = 0;

  logic        v_req_ready, v_bus_valid, v_resp_valid;
  logic [63:0] v_bus_addr, v_bus_wdata;
  logic [2:0]  v_bus_size;
  logic [7:0]  v_bus_strobe;

  always_comb begin
    if (cur_sel) begin
      v_req_ready  = rdy32;
      v_bus_valid  = bv32;
      v_resp_valid = rv32;
      v_bus_addr   = {32'b0, ba32};
      v_bus_wdata  = {32'b0, bw32};
      v_bus_size   = bs32;
      v_bus_strobe = {4'b0, bst32};
    end else begin
      v_req_ready  = rdy64;
      v_bus_valid  = bv64;
      v_resp_valid = rv64;
      v_bus_addr   = ba64;
      v_bus_wdata  = bw64;
      v_bus_size   = bs64;
      v_bus_strobe = bst64;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every response from either unit is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rv64 || rv32) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_unit", {63'b0, rv32}, {63'b0, e.sel});
        check("resp_rdata", rv32 ? {32'b0, rd32} : rd64, e.rdata);
        check("resp_misalign", {63'b0, rv32 ? mis32 : mis64}, {63'b0, e.fault});
      end
    end
  end

  task automatic access(input bit sel, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [2:0] sz, input int wait_cyc,
                        input logic [63:0] brd, input bit exp_fault, input logic [7:0] exp_strb,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_rdata);
    int guard;
    cur_sel = sel;
    guard = 0;
    while (!v_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", {63'b0, v_req_ready}, 64'd1);
    exp_q.push_back('{sel, exp_rdata, exp_fault});
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_size  = sz;
    if (sel) req_valid32 = 1'b1;
    else     req_valid64 = 1'b1;
    @(negedge clk);
    req_valid64 = 1'b0;
    req_valid32 = 1'b0;
    if (exp_fault) begin
      check("fault_no_bus", {63'b0, v_bus_valid}, 64'd0);
      check("fault_resp_latency", {63'b0, v_resp_valid}, 64'd1);
    end else begin
      check("bus_valid", {63'b0, v_bus_valid}, 64'd1);
      check("bus_addr", v_bus_addr, addr);
      check("bus_size", {61'b0, v_bus_size}, {61'b0, 1'b0, sz[1:0]});
      check("bus_strobe", {56'b0, v_bus_strobe}, {56'b0, exp_strb});
      check("bus_wdata", v_bus_wdata, exp_wdata);
      for (int i = 0; i < wait_cyc; i++) begin
        @(negedge clk);
        check("bus_hold_valid", {63'b0, v_bus_valid}, 64'd1);
        check("bus_hold_strobe", {56'b0, v_bus_strobe}, {56'b0, exp_strb});
        check("bus_hold_addr", v_bus_addr, addr);
        check("no_early_resp", {63'b0, v_resp_valid}, 64'd0);
      end
      bus_data_ok = 1'b1;
      bus_rdata   = brd;
      @(negedge clk);
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      check("bus_released", {63'b0, v_bus_valid}, 64'd0);
      check("resp_latency", {63'b0, v_resp_valid}, 64'd1);
    end
    @(negedge clk);
    check("resp_one_cycle", {63'b0, v_resp_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid64 = 0; req_valid32 = 0; req_write = 0;
    req_addr = '0; req_wdata = '0; req_size = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready_low", {63'b0, rdy64}, 64'd0);
    check("rst_bus_valid", {63'b0, bv64}, 64'd0);
    check("rst_resp_valid", {63'b0, rv64}, 64'd0);
    check("rst_strobe", {56'b0, bst64}, 64'd0);
    check("rst_rdata", rd64, 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", {63'b0, rdy64}, 64'd1);
    check("ready32_after_rst", {63'b0, rdy32}, 64'd1);

    // 64-bit unit: sel, wr, addr, wdata, size, wait, bus_rdata, fault, strobe, bus_wdata, rdata
    access(0, 0, 64'h1003, 64'h0, 3'b000, 3, 64'h0000_0000_8000_0000, 0, 8'h00, 64'h0,
           64'hFFFF_FFFF_FFFF_FF80);
    access(0, 1, 64'h2006, 64'hBEEF, 3'b001, 1, 64'h0, 0, 8'hC0, 64'hBEEF_0000_0000_0000,
           64'h0);
    access(0, 0, 64'h3002, 64'h0, 3'b110, 0, 64'h0, 1, 8'h00, 64'h0, 64'h0);
    access(0, 0, 64'h3004, 64'h0, 3'b110, 0, 64'hF000_0000_0000_0000, 0, 8'h00, 64'h0,
           64'h0000_0000_F000_0000);
    access(0, 0, 64'h3004, 64'h0, 3'b010, 2, 64'hF000_0000_0000_0000, 0, 8'h00, 64'h0,
           64'hFFFF_FFFF_F000_0000);
    access(0, 0, 64'h4000, 64'h0, 3'b011, 0, 64'h8123_4567_89AB_CDEF, 0, 8'h00, 64'h0,
           64'h8123_4567_89AB_CDEF);
    access(0, 1, 64'h4008, 64'h1122_3344_5566_7788, 3'b011, 0, 64'h0, 0, 8'hFF,
           64'h1122_3344_5566_7788, 64'h0);
    access(0, 0, 64'h5002, 64'h0, 3'b001, 1, 64'h0000_0000_8001_0000, 0, 8'h00, 64'h0,
           64'hFFFF_FFFF_FFFF_8001);
    access(0, 1, 64'h5001, 64'h1234, 3'b001, 0, 64'h0, 1, 8'h00, 64'h0, 64'h0);

    // 32-bit unit
    access(1, 0, 64'h0, 64'h0, 3'b011, 0, 64'h0, 1, 8'h00, 64'h0, 64'h0);
    access(1, 1, 64'h7, 64'h5A, 3'b000, 1, 64'h0, 0, 8'h08, 64'h5A00_0000, 64'h0);
    access(1, 0, 64'h2, 64'h0, 3'b001, 0, 64'h8765_0000, 0, 8'h00, 64'h0,
           64'h0000_0000_FFFF_8765);
    access(1, 0, 64'h4, 64'h0, 3'b010, 0, 64'h8000_0001, 0, 8'h00, 64'h0,
           64'h0000_0000_8000_0001);

    // reset while a store is waiting on the bus; the late data_ok must be ignored
    cur_sel = 0;
    req_write = 1; req_addr = 64'h6000; req_wdata = 64'h0123_4567_89AB_CDEF; req_size = 3'b011;
    req_valid64 = 1'b1;
    @(negedge clk);
    req_valid64 = 1'b0;
    check("mid_bus_valid", {63'b0, bv64}, 64'd1);
    reset = 1'b1;
    #1;
    check("ready_low_in_reset", {63'b0, rdy64}, 64'd0);
    @(negedge clk);
    check("rst_bus_drop", {63'b0, bv64}, 64'd0);
    check("rst_bus_addr", ba64, 64'd0);
    check("rst_bus_wdata", bw64, 64'd0);
    check("rst_bus_strobe", {56'b0, bst64}, 64'd0);
    check("rst_bus_size", {61'b0, bs64}, 64'd0);
    reset = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    bus_data_ok = 1'b0;
    check("late_ok_no_resp", {63'b0, rv64}, 64'd0);
    check("late_ok_no_bus", {63'b0, bv64}, 64'd0);
    check("ready_after_mid_rst", {63'b0, rdy64}, 64'd1);

    // back-to-back: second request held on req_valid while the first completes
    cur_sel = 0;
    exp_q.push_back('{1'b0, 64'h0000_0000_0000_00F0, 1'b0});
    req_write = 0; req_addr = 64'h10; req_wdata = '0; req_size = 3'b100;
    req_valid64 = 1'b1;
    @(negedge clk);
    check("b2b_a_bus", {63'b0, bv64}, 64'd1);
    check("b2b_a_addr", ba64, 64'h10);
    check("b2b_busy_ready", {63'b0, rdy64}, 64'd0);
    exp_q.push_back('{1'b0, 64'h0, 1'b0});
    req_write = 1; req_addr = 64'h14; req_wdata = 64'hCAFE_BABE; req_size = 3'b010;
    bus_data_ok = 1'b1;
    bus_rdata = 64'h0000_0000_0000_00F0;
    @(negedge clk);
    bus_data_ok = 1'b0;
    check("b2b_a_resp", {63'b0, rv64}, 64'd1);
    check("b2b_resp_ready", {63'b0, rdy64}, 64'd0);
    check("b2b_no_double", {63'b0, bv64}, 64'd0);
    @(negedge clk);
    check("b2b_idle_ready", {63'b0, rdy64}, 64'd1);
    check("b2b_b_not_yet", {63'b0, bv64}, 64'd0);
    @(negedge clk);
    req_valid64 = 1'b0;
    check("b2b_b_bus", {63'b0, bv64}, 64'd1);
    check("b2b_b_addr", ba64, 64'h14);
    check("b2b_b_strobe", {56'b0, bst64}, 64'h0000_0000_0000_00F0);
    check("b2b_b_wdata", bw64, 64'hCAFE_BABE_0000_0000);
    bus_data_ok = 1'b1;
    @(negedge clk);
    bus_data_ok = 1'b0;
    check("b2b_b_resp", {63'b0, rv64}, 64'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store unit between the execute/memory pipeline stage and the data bus.
- Accepts one request at a time and aligns store data and byte strobes to the bus lane.
- Holds the bus request stable until the bus acknowledges with `bus_data_ok`.
- Extracts load data and sign- or zero-extends it, flags misaligned or illegal accesses without touching the bus, and returns a registered one-cycle response.

Parameters:
- DATA_W, 64, bus/register data width in bits; 32 or 64 only.
- ADDR_W, 64, address width in bits.
- Derived: NB = DATA_W/8 (bus bytes); OW = log2(NB) (lane offset bits); SZ_MAX = OW.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline presents an access.
- req_ready  out  1  unit idle and able to accept.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (LSB = first byte).
- req_size  in  3  [1:0] log2 of access bytes; [2] = unsigned load (ignored for stores).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and faults.
- resp_misalign  out  1  access faulted; valid with resp_valid.
- bus_valid  out  1  bus request active.
- bus_addr  out  ADDR_W  request address, unmodified.
- bus_size  out  3  {1'b0, size[1:0]}.
- bus_strobe  out  NB  byte write enables; all 0 for loads.
- bus_wdata  out  DATA_W  lane-shifted store data.
- bus_addr_ok  in  1  address accepted by bus (informational).
- bus_data_ok  in  1  transfer complete.
- bus_rdata  in  DATA_W  full-lane read data, valid with bus_data_ok.

Behaviour:
- States: IDLE, BUS, RESP.
- `req_ready` = (state==IDLE) && !reset.
- Accept: when req_valid && req_ready, register the write flag, address, size, and the shifted data and strobe.
- Lane arithmetic: off = addr[OW-1:0]; bytes = 1<<size[1:0].
  - strobe = ((1<<bytes)-1) << off, truncated to NB bits.
  - bus_wdata = wdata << (off*8).
- Fault check (at accept):
  - misaligned if addr mod bytes != 0;
  - illegal if size[1:0] > SZ_MAX;
  - either condition sets the fault flag.
- IDLE -> RESP on accept with fault. No bus activity occurs, resp_rdata = 0, resp_misalign = 1.
- IDLE -> BUS on accept without fault.
- BUS: bus_valid = 1. bus_addr, bus_size, bus_strobe and bus_wdata stay constant until bus_data_ok. bus_addr_ok may coincide with or precede bus_data_ok and does not change state.
- BUS -> RESP on bus_data_ok.
  - Loads: capture field = bus_rdata >> (off*8), keep the low 8<<size bits, then sign-extend (size[2]=0) or zero-extend (size[2]=1) to DATA_W.
  - Stores: capture 0.
- RESP: resp_valid = 1 for exactly one cycle, then -> IDLE. The next request can be accepted in the following cycle.
- Latency:
  - faulted access: resp_valid one cycle after accept;
  - bus access: bus_valid one cycle after accept, resp_valid one cycle after bus_data_ok.
  - Zero-wait bus (data_ok in first BUS cycle): accept-to-resp = 2 cycles.
- bus_data_ok outside BUS is ignored. req_valid outside IDLE is ignored and must be held by the pipeline.
- 64-bit doubleword with DATA_W=64: full lane, strobe 0xFF, no extension.
- Reset (any state, including mid-BUS):
  - next state IDLE;
  - bus_valid, resp_valid, resp_misalign = 0;
  - resp_rdata, bus_addr, bus_wdata, bus_strobe, bus_size = 0;
  - the in-flight transfer is abandoned and a late bus_data_ok is ignored.

Test Plan:
1. DATA_W=64, load byte signed at addr 0x1003, bus_rdata=0x0000_0000_8000_0000 with data_ok after 3 cycles -> bus_strobe=0x00 held 3 cycles; resp_rdata=0xFFFF_FFFF_FFFF_FF80, resp_misalign=0.
2. Store halfword 0xBEEF at addr 0x2006 -> bus_strobe=0xC0, bus_wdata=0xBEEF_0000_0000_0000, bus_size=1; resp_valid one cycle after data_ok, resp_rdata=0.
3. Load word unsigned at 0x3002 -> no bus_valid ever; resp_valid the next cycle with resp_misalign=1, resp_rdata=0. Same size, signed, at 0x3004 with bus word 0xF000_0000 in upper lane -> resp_rdata=0x0000_0000_F000_0000 unsigned / 0xFFFF_FFFF_F000_0000 signed.
4. DATA_W=32, size[1:0]=3 at 0x0 -> resp_misalign=1, no bus transfer. Byte store 0x5A at 0x7 -> strobe 0x8, bus_wdata=0x5A00_0000.
5. Reset asserted in BUS state, bus_data_ok arrives the following cycle -> bus_valid=0, no resp_valid, req_ready=1 after reset deasserts.
6. Back-to-back: zero-wait bus and a second request held on req_valid -> second accept in the cycle after resp_valid. req_ready is low during BUS/RESP, so there is no double accept.
